// File: rtl/config_sequencer_pkg.sv
// Shared constants, FSM encoding and FIFO entry layout for the config sequencer.
// Select codes identify the tile sub-block that owns a config word.
package config_sequencer_pkg;

    localparam logic [15:0] CONFIG_SB     = 16'd7;
    localparam logic [15:0] CONFIG_CB0    = 16'd6;
    localparam logic [15:0] CONFIG_CB1    = 16'd5;
    localparam logic [15:0] CONFIG_CLB    = 16'd4;
    localparam logic [31:0] CFG_PARK_ADDR = 32'h0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRIVE,
        ST_GAP,
        ST_DONE
    } seq_state_e;

    typedef struct packed {
        logic        last;
        logic [31:0] addr;
        logic [31:0] data;
    } fifo_entry_t;

    localparam int ENTRY_W = $bits(fifo_entry_t);

    function automatic logic sel_is_legal(input logic [31:0] addr);
        logic [15:0] sel;
        sel = addr[31:16];
        return (sel == CONFIG_SB) || (sel == CONFIG_CB0) ||
               (sel == CONFIG_CB1) || (sel == CONFIG_CLB);
    endfunction

endpackage

// File: rtl/config_sequencer_if.sv
// Valid/ready word stream from the host or boot loader into the sequencer.
interface config_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [31:0] in_data;
    logic        in_last;

    modport master (output in_valid, in_addr, in_data, in_last, input in_ready);
    modport slave  (input in_valid, in_addr, in_data, in_last, output in_ready);
endinterface

// File: rtl/config_sequencer_fifo.sv
// Show-ahead synchronous FIFO; pointers carry one extra wrap bit for full/empty.
module config_sequencer_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

endmodule

// File: rtl/config_sequencer.sv
// Buffers {addr,data} words and plays them onto the shared tile config bus,
// holding each word HOLD_CYCLES cycles followed by GAP_CYCLES parked cycles.
module config_sequencer
    import config_sequencer_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = 1,
    parameter int GAP_CYCLES  = 1
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               start_i,
    config_sequencer_if.slave  in_if,
    output logic [31:0]        config_addr_o,
    output logic [31:0]        config_data_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_bad_sel_o,
    output logic [15:0]        word_count_o
);
    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    seq_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_q, last_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic [15:0]       count_q, count_d;

    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_rdata;
    fifo_entry_t        head;
    fifo_entry_t        push_entry;

    assign push_entry = '{last: in_if.in_last, addr: in_if.in_addr, data: in_if.in_data};
    assign head       = fifo_entry_t'(fifo_rdata);
    assign in_if.in_ready = !fifo_full || pop;

    config_sequencer_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (in_if.in_valid && in_if.in_ready),
        .pop_i   (pop),
        .wdata_i (push_entry),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        addr_d  = addr_q;
        data_d  = data_q;
        busy_d  = busy_q;
        err_d   = err_q;
        count_d = count_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    count_d = '0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (!fifo_empty) begin
                    pop    = 1'b1;
                    last_d = head.last;
                    if (sel_is_legal(head.addr)) begin
                        addr_d  = head.addr;
                        data_d  = head.data;
                        cnt_d   = HOLD_LOAD;
                        state_d = ST_DRIVE;
                        if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
                    end else begin
                        // Illegal selects never reach the bus; they only leave a sticky flag.
                        err_d   = 1'b1;
                        state_d = head.last ? ST_DONE : ST_FETCH;
                    end
                end
            end
            ST_DRIVE: begin
                if (cnt_q == '0) begin
                    addr_d = CFG_PARK_ADDR;
                    data_d = '0;
                    if (GAP_CYCLES > 0) begin
                        cnt_d   = GAP_LOAD;
                        state_d = ST_GAP;
                    end else begin
                        state_d = last_q ? ST_DONE : ST_FETCH;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    state_d = last_q ? ST_DONE : ST_FETCH;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            addr_q  <= CFG_PARK_ADDR;
            data_q  <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    assign config_addr_o = addr_q;
    assign config_data_o = data_q;
    assign busy_o        = busy_q;
    assign done_o        = (state_q == ST_DONE);
    assign err_bad_sel_o = err_q;
    assign word_count_o  = count_q;

endmodule

// File: tb/tb_config_sequencer.sv
// Two sequencer instances (HOLD=1/GAP=1 and HOLD=3/GAP=0) checked cycle by cycle
// against a bus timeline computed from the per-word hold/gap rules.
`timescale 1ns/1ps
module tb_config_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [1:0]  start_s;
    logic [1:0]  vld;
    logic [1:0]  lst;
    logic [1:0]  rdy;
    logic [31:0] a_in [2];
    logic [31:0] d_in [2];
    logic [31:0] cad  [2];
    logic [31:0] cdt  [2];
    logic [1:0]  busy;
    logic [1:0]  done;
    logic [1:0]  err;
    logic [15:0] wc   [2];

    int checks = 0;
    int errors = 0;
    int hold_c [2];
    int gap_c  [2];

    logic [31:0] q_addr [$];
    logic [31:0] q_data [$];

    config_sequencer_if if_a ();
    config_sequencer_if if_b ();

    assign if_a.in_valid = vld[0];
    assign if_a.in_addr  = a_in[0];
    assign if_a.in_data  = d_in[0];
    assign if_a.in_last  = lst[0];
    assign rdy[0]        = if_a.in_ready;
    assign if_b.in_valid = vld[1];
    assign if_b.in_addr  = a_in[1];
    assign if_b.in_data  = d_in[1];
    assign if_b.in_last  = lst[1];
    assign rdy[1]        = if_b.in_ready;

    config_sequencer #(.FIFO_DEPTH(4), .HOLD_CYCLES(1), .GAP_CYCLES(1)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start_s[0]), .in_if(if_a),
        .config_addr_o(cad[0]), .config_data_o(cdt[0]), .busy_o(busy[0]),
        .done_o(done[0]), .err_bad_sel_o(err[0]), .word_count_o(wc[0])
    );

    config_sequencer #(.FIFO_DEPTH(4), .HOLD_CYCLES(3), .GAP_CYCLES(0)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start_s[1]), .in_if(if_b),
        .config_addr_o(cad[1]), .config_data_o(cdt[1]), .busy_o(busy[1]),
        .done_o(done[1]), .err_bad_sel_o(err[1]), .word_count_o(wc[1])
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add_word(input logic [15:0] sel);
        logic [15:0] tile;
        tile = 16'($urandom);
        q_addr.push_back({sel, tile});
        q_data.push_back($urandom);
    endtask

    function automatic logic [15:0] bad_sel();
        logic [15:0] s;
        if ($urandom_range(1, 0) == 1) s = 16'($urandom_range(3, 0));
        else                           s = 16'($urandom_range(65535, 8));
        return s;
    endfunction

    // Presents word i with valid held high; returns once it has been accepted.
    task automatic push_word(input int d, input int i);
        bit ok;
        vld[d]  = 1'b1;
        a_in[d] = q_addr[i];
        d_in[d] = q_data[i];
        lst[d]  = (i == q_addr.size() - 1);
        ok = 1'b0;
        for (int k = 0; k < 60 && !ok; k++) begin
            if (rdy[d] === 1'b1) ok = 1'b1;
            step();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL push_accept dut%0d word%0d: got no accept, required accept within 60 cycles", d, i);
        end else begin
            $display("push dut%0d word%0d addr=%h data=%h last=%0d", d, i, q_addr[i], q_data[i], lst[d]);
        end
    endtask

    task automatic do_start(input int d, input bit keep_high);
        start_s[d] = 1'b1;
        step();
        if (!keep_high) start_s[d] = 1'b0;
    endtask

    // Expected timeline: each word costs one fetch cycle; a legal word then owns the
    // bus for HOLD cycles and leaves GAP parked cycles; DONE follows the last word.
    task automatic check_trace(input int d, input bit pulse_busy);
        logic [31:0] ea [128];
        logic [31:0] ed [128];
        int t, done_t, n_legal;
        bit any_bad;
        logic [15:0] sel;
        for (int c = 0; c < 128; c++) begin
            ea[c] = 32'h0;
            ed[c] = 32'h0;
        end
        t = 0; n_legal = 0; any_bad = 1'b0;
        for (int i = 0; i < q_addr.size(); i++) begin
            sel = q_addr[i][31:16];
            if (sel >= 16'd4 && sel <= 16'd7) begin
                for (int h = 1; h <= hold_c[d]; h++) begin
                    ea[t + h] = q_addr[i];
                    ed[t + h] = q_data[i];
                end
                t += 1 + hold_c[d] + gap_c[d];
                n_legal++;
            end else begin
                t += 1;
                any_bad = 1'b1;
            end
        end
        done_t = t;
        for (int c = 0; c <= done_t + 1; c++) begin
            checks++;
            if (cad[d] !== ea[c]) begin
                errors++;
                $display("FAIL bus_addr dut%0d t=%0d: got %h, required %h", d, c, cad[d], ea[c]);
            end
            checks++;
            if (cdt[d] !== ed[c]) begin
                errors++;
                $display("FAIL bus_data dut%0d t=%0d: got %h, required %h", d, c, cdt[d], ed[c]);
            end
            checks++;
            if (done[d] !== (c == done_t)) begin
                errors++;
                $display("FAIL done dut%0d t=%0d: got %b, required %b", d, c, done[d], (c == done_t));
            end
            checks++;
            if (busy[d] !== (c <= done_t)) begin
                errors++;
                $display("FAIL busy dut%0d t=%0d: got %b, required %b", d, c, busy[d], (c <= done_t));
            end
            if (c <= done_t) step();
        end
        if (pulse_busy) start_s[d] = 1'b0;
        checks++;
        if (wc[d] !== 16'(n_legal)) begin
            errors++;
            $display("FAIL word_count dut%0d: got %0d, required %0d", d, wc[d], n_legal);
        end
        checks++;
        if (err[d] !== any_bad) begin
            errors++;
            $display("FAIL err_bad_sel dut%0d: got %b, required %b", d, err[d], any_bad);
        end
        $display("session dut%0d words=%0d legal=%0d done_at=%0d", d, q_addr.size(), n_legal, done_t);
    endtask

    task automatic run_session(input int d, input bit pulse_busy);
        for (int i = 0; i < q_addr.size(); i++) push_word(d, i);
        vld[d] = 1'b0;
        do_start(d, pulse_busy);
        check_trace(d, pulse_busy);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (cad[d] !== 32'h0 || cdt[d] !== 32'h0) begin
                errors++;
                $display("FAIL reset_bus dut%0d: got %h/%h, required 0/0", d, cad[d], cdt[d]);
            end
            checks++;
            if (busy[d] !== 1'b0 || done[d] !== 1'b0 || err[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_flags dut%0d: got busy=%b done=%b err=%b, required 0", d, busy[d], done[d], err[d]);
            end
            checks++;
            if (wc[d] !== 16'h0) begin
                errors++;
                $display("FAIL reset_count dut%0d: got %0d, required 0", d, wc[d]);
            end
            checks++;
            if (rdy[d] !== 1'b1) begin
                errors++;
                $display("FAIL reset_ready dut%0d: got %b, required 1", d, rdy[d]);
            end
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic_stream();
        q_addr.delete(); q_data.delete();
        q_addr.push_back(32'h0007_0003); q_data.push_back($urandom);
        q_addr.push_back(32'h0006_0003); q_data.push_back($urandom);
        q_addr.push_back(32'h0004_0003); q_data.push_back($urandom);
        run_session(0, 1'b0);
    endtask

    task automatic test_bad_select();
        q_addr.delete(); q_data.delete();
        add_word(16'd7);
        add_word(16'd3);
        add_word(16'd5);
        run_session(0, 1'b0);
    endtask

    task automatic test_ignored_start();
        q_addr.delete(); q_data.delete();
        add_word(16'd2);
        run_session(0, 1'b1);
    endtask

    task automatic test_hold_no_gap();
        q_addr.delete(); q_data.delete();
        for (int i = 0; i < 3; i++) add_word(16'($urandom_range(7, 4)));
        run_session(1, 1'b0);
    endtask

    task automatic test_backpressure();
        q_addr.delete(); q_data.delete();
        for (int i = 0; i < 6; i++) add_word(16'($urandom_range(7, 4)));
        for (int i = 0; i < 4; i++) push_word(0, i);
        vld[0] = 1'b1; a_in[0] = q_addr[4]; d_in[0] = q_data[4]; lst[0] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rdy[0] !== 1'b0) begin
                errors++;
                $display("FAIL ready_when_full k=%0d: got %b, required 0", k, rdy[0]);
            end
            step();
        end
        do_start(0, 1'b0);
        checks++;
        if (rdy[0] !== 1'b1) begin
            errors++;
            $display("FAIL ready_in_pop_cycle: got %b, required 1", rdy[0]);
        end
        fork
            begin
                push_word(0, 4);
                push_word(0, 5);
                vld[0] = 1'b0;
            end
            check_trace(0, 1'b0);
        join
    endtask

    task automatic test_async_reset();
        q_addr.delete(); q_data.delete();
        add_word(16'd6);
        add_word(16'd5);
        push_word(0, 0);
        push_word(0, 1);
        vld[0] = 1'b0;
        do_start(0, 1'b0);
        step();
        checks++;
        if (cad[0] !== q_addr[0]) begin
            errors++;
            $display("FAIL pre_reset_drive: got %h, required %h", cad[0], q_addr[0]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (cad[0] !== 32'h0 || cdt[0] !== 32'h0) begin
            errors++;
            $display("FAIL async_reset_bus: got %h/%h, required 0/0", cad[0], cdt[0]);
        end
        checks++;
        if (busy[0] !== 1'b0 || done[0] !== 1'b0 || err[0] !== 1'b0 || wc[0] !== 16'h0) begin
            errors++;
            $display("FAIL async_reset_state: got busy=%b done=%b err=%b count=%0d, required all 0",
                     busy[0], done[0], err[0], wc[0]);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        q_addr.delete(); q_data.delete();
        add_word(16'd4);
        run_session(0, 1'b0);
    endtask

    task automatic test_random();
        int d, n;
        for (int s = 0; s < 8; s++) begin
            d = $urandom_range(1, 0);
            n = $urandom_range(4, 1);
            q_addr.delete(); q_data.delete();
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(3, 0) == 0) add_word(bad_sel());
                else                           add_word(16'($urandom_range(7, 4)));
            end
            run_session(d, 1'($urandom_range(1, 0)));
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        start_s = '0;
        vld     = '0;
        lst     = '0;
        for (int d = 0; d < 2; d++) begin
            a_in[d] = 32'h0;
            d_in[d] = 32'h0;
        end
        hold_c[0] = 1; gap_c[0] = 1;
        hold_c[1] = 3; gap_c[1] = 0;
        test_reset();
        test_basic_stream();
        test_bad_select();
        test_ignored_start();
        test_hold_no_gap();
        test_backpressure();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
